// File: rtl/gpio_bank_pkg.sv
// Shared constants for the gpio_bank register bank: bus widths, register ids
// and the slice-count helper.
package gpio_bank_pkg;

  localparam int BUS_AW = 8;
  localparam int BUS_DW = 32;

  localparam logic [3:0] REG_OUT      = 4'd0;
  localparam logic [3:0] REG_OE       = 4'd1;
  localparam logic [3:0] REG_IN       = 4'd2;
  localparam logic [3:0] REG_SET      = 4'd3;
  localparam logic [3:0] REG_CLR      = 4'd4;
  localparam logic [3:0] REG_TGL      = 4'd5;
  localparam logic [3:0] REG_IRQ_RISE = 4'd6;
  localparam logic [3:0] REG_IRQ_FALL = 4'd7;
  localparam logic [3:0] REG_IRQ_STAT = 4'd8;

  // Number of 32-bit bus slices needed to cover n pins.
  function automatic int calc_nw(input int n);
    return (n + 31) / 32;
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// Register-bus bundle between the user core (master) and gpio_bank (slave).
interface gpio_bank_if;
  import gpio_bank_pkg::*;

  logic [BUS_AW-1:0] bus_addr;
  logic [BUS_DW-1:0] bus_wdata;
  logic              bus_we;
  logic              bus_re;
  logic [BUS_DW-1:0] bus_rdata;
  logic              bus_rvalid;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re,
    input  bus_rdata, bus_rvalid
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re,
    output bus_rdata, bus_rvalid
  );

endinterface

// File: rtl/gpio_in_cond.sv
// Per-pin input conditioning: synchroniser, optional debounce filter
// (GPIO_DEBOUNCE_EN) and rise/fall detection against the previous sample.
module gpio_in_cond #(
  parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic pad_i,
  output logic val_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt_s;
  logic                   prev_q;

  // Synchroniser shift chain; the oldest stage is the settled sample.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Count consecutive cycles the sample disagrees with the filtered value;
  // any agreement restarts the count so short glitches never propagate.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync_q[SYNC_STAGES-1];
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_s = filt_q;
`else
  assign filt_s = sync_q[SYNC_STAGES-1];
`endif

  // Previous filtered sample for edge detection.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= filt_s;
    end
  end

  assign val_o  = filt_s;
  assign rise_o = filt_s & ~prev_q;
  assign fall_o = ~filt_s & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// Register-programmable GPIO bank: output/drive-enable, synchronised inputs,
// set/clear/toggle and edge interrupts. Optional debounce: GPIO_DEBOUNCE_EN.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int NUM_IO          = 36,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  gpio_bank_if.slave        bus,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              irq
);

  localparam int NW = calc_nw(NUM_IO);

  if (NUM_IO < 1 || NUM_IO > 512 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("gpio_bank: illegal parameter value");
  end

  logic [3:0]        reg_id_s, slice_s;
  logic [NUM_IO-1:0] hit_s, wmask_s, w1c_s;
  logic [NUM_IO-1:0] in_s, rise_s, fall_s;
  logic [NUM_IO-1:0] out_q, out_d, oe_q, oe_d;
  logic [NUM_IO-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [NUM_IO-1:0] stat_q, stat_d;
  logic [NUM_IO-1:0] rd_bits_s;
  logic [NW*32-1:0]  rd_pad_s;
  logic [31:0]       rd_word_s;
  logic [31:0]       rdata_q;
  logic              rvalid_q, irq_q;

  assign reg_id_s = bus.bus_addr[7:4];
  assign slice_s  = bus.bus_addr[3:0];

  for (genvar p = 0; p < NUM_IO; p++) begin : g_pin
    gpio_in_cond #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
      , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
    ) u_cond (
      .clk_i  (clk_i),
      .rst_n  (rst_n),
      .pad_i  (io_in[p]),
      .val_o  (in_s[p]),
      .rise_o (rise_s[p]),
      .fall_o (fall_s[p])
    );
  end

  // Map the 32-bit write word onto the pins of the addressed slice; slices
  // beyond the bank and bits above NUM_IO simply have no pin to land on.
  always_comb begin
    hit_s   = '0;
    wmask_s = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      hit_s[i]   = (slice_s == 4'(i / 32));
      wmask_s[i] = hit_s[i] & bus.bus_wdata[i % 32];
    end
  end

  // Register next-state; an edge in the same cycle as its W1C keeps the bit set.
  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_s     = '0;
    if (bus.bus_we) begin
      case (reg_id_s)
        REG_OUT:      out_d     = (out_q & ~hit_s) | wmask_s;
        REG_OE:       oe_d      = (oe_q & ~hit_s) | wmask_s;
        REG_SET:      out_d     = out_q | wmask_s;
        REG_CLR:      out_d     = out_q & ~wmask_s;
        REG_TGL:      out_d     = out_q ^ wmask_s;
        REG_IRQ_RISE: rise_en_d = (rise_en_q & ~hit_s) | wmask_s;
        REG_IRQ_FALL: fall_en_d = (fall_en_q & ~hit_s) | wmask_s;
        REG_IRQ_STAT: w1c_s     = wmask_s;
        default:      w1c_s     = '0;
      endcase
    end else begin
      w1c_s = '0;
    end
    stat_d = (stat_q & ~w1c_s) | (rise_s & rise_en_q) | (fall_s & fall_en_q);
  end

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    case (reg_id_s)
      REG_OUT:      rd_bits_s = out_q;
      REG_OE:       rd_bits_s = oe_q;
      REG_IN:       rd_bits_s = in_s;
      REG_IRQ_RISE: rd_bits_s = rise_en_q;
      REG_IRQ_FALL: rd_bits_s = fall_en_q;
      REG_IRQ_STAT: rd_bits_s = stat_q;
      default:      rd_bits_s = '0;
    endcase
    rd_pad_s               = '0;
    rd_pad_s[NUM_IO-1:0]   = rd_bits_s;
    rd_word_s              = 32'h0;
    for (int w = 0; w < NW; w++) begin
      if (slice_s == 4'(w)) begin
        rd_word_s = rd_pad_s[w*32 +: 32];
      end else begin
        rd_word_s = rd_word_s;
      end
    end
  end

  // Register bank, read response and interrupt output.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      rdata_q   <= 32'h0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      rdata_q   <= bus.bus_re ? rd_word_s : 32'h0;
      rvalid_q  <= bus.bus_re;
      irq_q     <= |stat_q;
    end
  end

  assign bus.bus_rdata  = rdata_q;
  assign bus.bus_rvalid = rvalid_q;
  assign io_out         = out_q;
  assign io_oeb         = ~oe_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank: reads push expected data, a negedge monitor
// pops and compares on every bus_rvalid; pad/irq pins are checked directly.
module tb_gpio_bank;
  import gpio_bank_pkg::*;

`ifdef GPIO_DEBOUNCE_EN
  localparam int DLY = 16;
`else
  localparam int DLY = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic [35:0] io_in = '0;
  logic [35:0] io_out, io_oeb;
  logic        irq;

  gpio_bank_if bus ();

  gpio_bank #(.NUM_IO(36), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .bus    (bus),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb),
    .irq    (irq)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wr(input logic [3:0] id, input logic [3:0] sl, input logic [31:0] d);
    bus.bus_addr  = {id, sl};
    bus.bus_wdata = d;
    bus.bus_we    = 1'b1;
    @(negedge clk_i);
    bus.bus_we    = 1'b0;
  endtask

  task automatic rd(input string name, input logic [3:0] id, input logic [3:0] sl, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    bus.bus_addr = {id, sl};
    bus.bus_re   = 1'b1;
    @(negedge clk_i);
    bus.bus_re   = 1'b0;
  endtask

  task automatic rdwr(input string name, input logic [3:0] id, input logic [3:0] sl,
                      input logic [31:0] d, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    bus.bus_addr  = {id, sl};
    bus.bus_wdata = d;
    bus.bus_we    = 1'b1;
    bus.bus_re    = 1'b1;
    @(negedge clk_i);
    bus.bus_we    = 1'b0;
    bus.bus_re    = 1'b0;
  endtask

  // Monitor: every read response is matched against the oldest expectation.
  always @(negedge clk_i) begin
    if (bus.bus_rvalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rvalid: got rdata %0h want no response", bus.bus_rdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.bus_rdata !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %0h want %0h", e.name, bus.bus_rdata, e.exp);
        end
      end
    end
  end

  initial begin
    bus.bus_addr  = 8'h00;
    bus.bus_wdata = 32'h0;
    bus.bus_we    = 1'b0;
    bus.bus_re    = 1'b0;

    // Reset state
    #12;
    chk("rst_oeb", io_oeb, 64'h0000_000F_FFFF_FFFF);
    chk("rst_out", io_out, 64'h0);
    chk("rst_irq", irq, 64'h0);
    chk("rst_rvalid", bus.bus_rvalid, 64'h0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    rd("rd_oe_rst", REG_OE, 4'd0, 32'h0);

    // Outputs and atomic ops on slice 1 (pins 32..35)
    wr(REG_OE, 4'd1, 32'h0000_000F);
    wr(REG_OUT, 4'd1, 32'h0000_0005);
    wr(REG_SET, 4'd1, 32'h0000_0002);
    wr(REG_TGL, 4'd1, 32'h0000_0001);
    chk("pad_oeb", io_oeb, 64'h0000_0000_FFFF_FFFF);
    chk("pad_out", io_out, 64'h0000_0006_0000_0000);
    rd("rd_out_s1", REG_OUT, 4'd1, 32'h0000_0006);
    rd("rd_oe_s1", REG_OE, 4'd1, 32'h0000_000F);
    wr(REG_CLR, 4'd1, 32'h0000_0004);
    rd("rd_out_clr", REG_OUT, 4'd1, 32'h0000_0002);
    wr(REG_OUT, 4'd1, 32'hFFFF_FFFF);
    rd("rd_out_top", REG_OUT, 4'd1, 32'h0000_000F);
    chk("pad_out_f", io_out, 64'h0000_000F_0000_0000);
    rd("rd_set_wo", REG_SET, 4'd1, 32'h0);
    rd("rd_slice2", REG_OUT, 4'd2, 32'h0);
    wr(4'd9, 4'd0, 32'hFFFF_FFFF);
    rd("rd_unused_id", 4'd9, 4'd0, 32'h0);
    rdwr("rd_prewrite", REG_OUT, 4'd1, 32'h0000_0003, 32'h0000_000F);
    rd("rd_postwrite", REG_OUT, 4'd1, 32'h0000_0003);

    // Rising edge on pin 0
    wr(REG_IRQ_RISE, 4'd0, 32'h0000_0001);
    rd("rd_rise_en", REG_IRQ_RISE, 4'd0, 32'h0000_0001);
    io_in[0] = 1'b1;
    @(negedge clk_i);
    wait_cyc(DLY);
    rd("rd_in_early", REG_IN, 4'd0, 32'h0);
    rd("rd_in_bit0", REG_IN, 4'd0, 32'h0000_0001);
    chk("irq_not_yet", irq, 64'h0);
    rd("rd_stat0", REG_IRQ_STAT, 4'd0, 32'h0000_0001);
    chk("irq_set", irq, 64'h1);
    wr(REG_IRQ_STAT, 4'd0, 32'h0000_0001);
    chk("irq_hold", irq, 64'h1);
    @(negedge clk_i);
    chk("irq_clr", irq, 64'h0);
    rd("rd_stat_w1c", REG_IRQ_STAT, 4'd0, 32'h0);

    // Falling edge with fall disabled, then rise-enable while already high
    io_in[0] = 1'b0;
    wait_cyc(4 + DLY);
    rd("rd_stat_nofall", REG_IRQ_STAT, 4'd0, 32'h0);
    chk("irq_nofall", irq, 64'h0);
    io_in[1] = 1'b1;
    wait_cyc(4 + DLY);
    wr(REG_IRQ_RISE, 4'd0, 32'h0000_0003);
    wait_cyc(3);
    rd("rd_stat_lvl", REG_IRQ_STAT, 4'd0, 32'h0);
    rd("rd_in_lvl", REG_IN, 4'd0, 32'h0000_0002);

    // Falling edge with fall enabled on pin 1
    wr(REG_IRQ_FALL, 4'd0, 32'h0000_0002);
    io_in[1] = 1'b0;
    wait_cyc(4 + DLY);
    rd("rd_stat_fall", REG_IRQ_STAT, 4'd0, 32'h0000_0002);
    wr(REG_IRQ_STAT, 4'd0, 32'h0000_0002);
    rd("rd_stat_fclr", REG_IRQ_STAT, 4'd0, 32'h0);

    // Edge on pin 3 collides with W1C of bit 3
    wr(REG_IRQ_RISE, 4'd0, 32'h0000_000B);
    io_in[3] = 1'b1;
    wait_cyc(2 + DLY);
    wr(REG_IRQ_STAT, 4'd0, 32'h0000_0008);
    rd("rd_set_wins", REG_IRQ_STAT, 4'd0, 32'h0000_0008);

`ifdef GPIO_DEBOUNCE_EN
    // Debounce: short glitch filtered, long pulse passes once
    wr(REG_IRQ_RISE, 4'd0, 32'h0000_002B);
    io_in[5] = 1'b1;
    wait_cyc(10);
    io_in[5] = 1'b0;
    wait_cyc(30);
    rd("rd_in_glitch", REG_IN, 4'd0, 32'h0000_0008);
    rd("rd_stat_glitch", REG_IRQ_STAT, 4'd0, 32'h0000_0008);
    io_in[5] = 1'b1;
    wait_cyc(17);
    rd("rd_in_db_early", REG_IN, 4'd0, 32'h0000_0008);
    rd("rd_in_db", REG_IN, 4'd0, 32'h0000_0028);
    wait_cyc(1);
    io_in[5] = 1'b0;
    rd("rd_stat_db", REG_IRQ_STAT, 4'd0, 32'h0000_0028);
    wait_cyc(40);
    rd("rd_stat_db_once", REG_IRQ_STAT, 4'd0, 32'h0000_0028);
    wr(REG_IRQ_STAT, 4'd0, 32'h0000_0020);
    rd("rd_stat_db_clr", REG_IRQ_STAT, 4'd0, 32'h0000_0008);
`endif

    // Asynchronous reset while irq is pending and pins are driven
    wait_cyc(2);
    chk("pre_rst_irq", irq, 64'h1);
    chk("pre_rst_out", io_out, 64'h0000_0003_0000_0000);
    chk("pre_rst_oeb", io_oeb, 64'h0000_0000_FFFF_FFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_irq", irq, 64'h0);
    chk("arst_out", io_out, 64'h0);
    chk("arst_oeb", io_oeb, 64'h0000_000F_FFFF_FFFF);
    chk("arst_rvalid", bus.bus_rvalid, 64'h0);

    wait_cyc(3);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_drain: got %0d outstanding reads want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised GPIO controller that replaces hard-wired pad tristating with a register-programmable bank.
- Provides per-pin output and drive-enable, synchronised input sampling, atomic set/clear/toggle, and edge-triggered interrupts.
- Sits between the user-project core (simple register bus) and the io_in/io_out/io_oeb pad signals.

Parameters:
- NUM_IO, 36, number of pins (1..512); bus slices NW = ceil(NUM_IO/32).
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- DEBOUNCE_CYCLES, 16, stable-cycle count for the debounce filter (only used with GPIO_DEBOUNCE_EN).

Ports:
- clk_i  in  1  single clock domain
- rst_n  in  1  asynchronous active-low reset
- bus_addr  in  8  [7:4] register id, [3:0] 32-bit slice index
- bus_wdata  in  32  write data
- bus_we  in  1  write strobe, one-cycle
- bus_re  in  1  read strobe, one-cycle
- bus_rdata  out  32  read data, registered
- bus_rvalid  out  1  high the cycle after bus_re
- io_in  in  NUM_IO  raw pad inputs (asynchronous)
- io_out  out  NUM_IO  pad output values
- io_oeb  out  NUM_IO  pad output-enable, active low (1 = high-Z)
- irq  out  1  OR of (IRQ_STAT), level, registered

Behaviour:
- Reset is asynchronous on rst_n low, all state cleared:
  - OUT=0, OE=0 (io_oeb all 1, all pins high-Z)
  - IRQ_RISE/IRQ_FALL/IRQ_STAT=0, sync chain=0, prev sample=0
  - bus_rdata=0, bus_rvalid=0, irq=0
- Register ids:
  - 0 OUT rw
  - 1 OE rw (1 = drive)
  - 2 IN ro (synchronised/filtered value)
  - 3 SET wo (OUT |= wdata)
  - 4 CLR wo (OUT &= ~wdata)
  - 5 TGL wo (OUT ^= wdata)
  - 6 IRQ_RISE rw
  - 7 IRQ_FALL rw
  - 8 IRQ_STAT rw1c
- Unused ids and slices >= NW: read 0, writes ignored.
- Bits >= NUM_IO in the top slice: read 0, writes ignored.
- Write-only registers read 0.
- Writes take effect at the clock edge with bus_we high. io_out and io_oeb are driven directly from the OUT/OE flops, so a write is visible on the pads the cycle after the strobe.
- Reads: bus_rdata and bus_rvalid are valid the cycle after bus_re. If bus_re and bus_we target the same register in one cycle, the read returns the pre-write value.
- Input path: io_in passes through SYNC_STAGES flops to give s; prev <= s every cycle.
  - rise = s & ~prev
  - fall = ~s & prev
  - An io_in change appears in IN after SYNC_STAGES cycles.
- Status update: IRQ_STAT <= (IRQ_STAT & ~w1c_mask) | (rise & IRQ_RISE) | (fall & IRQ_FALL).
  - An edge in the same cycle as a W1C of that bit leaves the bit set (set wins).
  - Enabling IRQ_RISE while the input is already high does not set status; only new edges count.
- irq is registered from |IRQ_STAT, so it rises one cycle after the status bit sets and deasserts one cycle after the final clear.
- Reset mid-operation: everything clears immediately and pads go high-Z; a pending irq drops asynchronously.

Optional Feature:
- GPIO_DEBOUNCE_EN defined: each pin gets a counter of width clog2(DEBOUNCE_CYCLES+1).
  - The filtered value f changes to s only after s has differed from f for DEBOUNCE_CYCLES consecutive cycles.
  - A glitch shorter than that resets the counter and produces no change or edge.
  - IN and the edge detection use f. Counter and f reset to 0.
- Undefined: f = s, no counters, and the DEBOUNCE_CYCLES parameter is unused.

Decomposition:
- Package gpio_bank_pkg holds:
  - register-id localparams: REG_OUT .. REG_IRQ_STAT
  - BUS_AW=8, BUS_DW=32
  - function for NW
- Sub-module gpio_in_cond: one instance per pin, generated NUM_IO times. It contains the sync chain, the optional debounce, prev, and the rise/fall outputs.
- The register file and bus logic live in gpio_bank.

Test Plan:
- Reset check: after reset, io_oeb all 1s, io_out 0, irq 0. Read OE slice 0 → rdata 0 with rvalid one cycle after re.
- Output write: write OE slice1=0xF (pins 32-35), OUT slice1=0x5, then SET slice1=0x2, TGL slice1=0x1.
  - io_oeb[35:32]=0, io_out[35:32] ends 0x6.
  - Write slice1=0xFFFFFFFF → reads back 0xF.
- Input and edges: IRQ_RISE slice0=0x1, drive io_in[0] 0→1.
  - IN bit0 = 1 after 2 cycles.
  - IRQ_STAT bit0 = 1, and irq = 1 one cycle later.
  - W1C 0x1 → irq 0. A falling edge with IRQ_FALL=0 sets nothing.
- Set-wins collision: align a rising edge on pin 3 with a W1C of bit 3 in the same cycle → IRQ_STAT bit3 stays 1.
- Debounce (GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16):
  - 10-cycle pulse on io_in[5] → no IN change, no status.
  - 20-cycle pulse → IN[5]=1 after 2+16 cycles, rise flagged once.
- Async reset mid-run: assert rst_n low while irq=1 and OE=0xF → irq and io_out drop immediately, io_oeb all 1 without waiting for a clock edge.
